// File: rtl/rgb565_pixel_unpacker_if.sv
// rgb565_pixel_unpacker stream bundle: packed-word input side,
// per-pixel output side and the frame-done strobe.
interface rgb565_pixel_unpacker_if #(
    parameter int XW = 5,
    parameter int YW = 5
);
    logic [31:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    out_r;
    logic [5:0]    out_g;
    logic [5:0]    out_b;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          out_sop;
    logic          out_eop;
    logic          out_valid;
    logic          out_ready;
    logic          frame_done;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_r, out_g, out_b, out_x, out_y,
        input  out_sop, out_eop, out_valid, frame_done
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_r, out_g, out_b, out_x, out_y,
        output out_sop, out_eop, out_valid, frame_done
    );
endinterface

// File: rtl/rgb565_pixel_unpacker.sv
// Splits 32-bit words of two RGB565 pixels into one pixel per cycle
// as 6-bit r/g/b codes, with raster position and frame markers.
module rgb565_pixel_unpacker #(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int XW         = $clog2(IMG_WIDTH),
    parameter int YW         = $clog2(IMG_HEIGHT)
) (
    input  logic                   clk,
    input  logic                   reset,
    rgb565_pixel_unpacker_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LO    = 2'd1,
        HI    = 2'd2
    } state_t;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    state_t        state_q, state_d;
    logic [31:0]   word_q, word_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          done_q, done_d;

    logic          out_valid;
    logic          in_ready;
    logic          in_acc;
    logic          out_acc;
    logic          at_eop;
    logic [15:0]   pix;

    // Handshake decode; both sides are held off while reset is high.
    always_comb begin
        out_valid = !reset && (state_q != EMPTY);
        in_ready  = !reset && ((state_q == EMPTY) ||
                               ((state_q == HI) && bus.out_ready));
        in_acc    = bus.in_valid && in_ready;
        out_acc   = out_valid && bus.out_ready;
        at_eop    = (x_q == X_LAST) && (y_q == Y_LAST);
        pix       = (state_q == HI) ? word_q[31:16] : word_q[15:0];
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_r      = {1'b0, pix[15:11]};
    assign bus.out_g      = pix[10:5];
    assign bus.out_b      = {1'b0, pix[4:0]};
    assign bus.out_x      = x_q;
    assign bus.out_y      = y_q;
    assign bus.out_sop    = out_valid && (x_q == '0) && (y_q == '0);
    assign bus.out_eop    = out_valid && at_eop;
    assign bus.frame_done = done_q;

    // Phase FSM, word capture, raster counters and frame-done strobe.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = out_acc && at_eop;

        case (state_q)
            EMPTY: begin
                if (in_acc) begin
                    state_d = LO;
                    word_d  = bus.in_data;
                end
            end
            LO: begin
                if (out_acc) begin
                    state_d = HI;
                end
            end
            HI: begin
                if (out_acc) begin
                    if (in_acc) begin
                        state_d = LO;
                        word_d  = bus.in_data;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (out_acc) begin
            if (at_eop) begin
                x_d = '0;
                y_d = '0;
            end else if (x_q == X_LAST) begin
                x_d = '0;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            word_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end
endmodule
